aes_seq_ctrl: RTL and testbench
===============================

Name: aes_seq_ctrl

Overview:
- Sequences one AES-128 operation for the CSR-mapped AES extension: triggered by a CSR write of the key address, fetches the 128-bit key from memory, starts the AES core, waits for completion, and hands the 4 result words back to the CSR register file with a one-cycle aes_done pulse.
- Sits between the CSR write-back path, the data-memory read port (simple req/ack) and the AES core.

Parameters:
- TRIG_ADDR, 12'h7C4, CSR address whose write starts an operation (AES key address CSR).
- TIMEOUT, 1024, maximum cycles spent in WAIT before an error completion; legal range 1..65535.

Ports:
- clk  in  1  clock, all state on rising edge
- nrst  in  1  asynchronous active-low reset
- csr_we  in  1  CSR write-back enable
- csr_address_wb  in  12  CSR write-back address
- csr_wb  in  32  CSR write-back data; captured as key address on trigger
- exception_pending  in  1  trigger suppressed when high
- aes_d0_i, aes_d1_i, aes_d2_i, aes_d3_i  in  32 each  plaintext words from CSR file
- mem_req  out  1  key-word read request
- mem_addr  out  32  key-word byte address, word aligned
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  32  key word
- core_start  out  1  one-cycle start pulse to AES core
- core_key  out  128  key to core
- core_data  out  128  plaintext to core
- core_done  in  1  core result valid (single cycle)
- core_res  in  128  core result
- aes_done  out  1  one-cycle completion pulse to CSR file
- aes_res0_o, aes_res1_o, aes_res2_o, aes_res3_o  out  32 each  result words
- busy  out  1  high in every state except IDLE
- err  out  1  sticky: last operation timed out; cleared on next trigger

Behaviour:
- Reset (async, nrst=0): state IDLE; mem_req=0, mem_addr=0, core_start=0, core_key=0, core_data=0, aes_done=0, aes_res*=0, busy=0, err=0, word counter=0, timeout counter=0.
- Trigger = csr_we && csr_address_wb==TRIG_ADDR && !exception_pending, sampled in IDLE only. Triggers in any other state are ignored (no queueing).
- On trigger: base = {csr_wb[31:2],2'b00}, word counter=0, err cleared, go FETCH.
- FETCH: mem_req=1, mem_addr=base+4*cnt (32-bit add, wraps modulo 2^32). On mem_ack, store mem_rdata into core_key[127-32*cnt -: 32] and increment cnt. mem_addr updates the cycle after ack. After the 4th ack, mem_req drops the next cycle and state goes to START. mem_req stays high with a stable address until ack; there is no limit on ack latency.
- START (1 cycle): core_data={aes_d0_i,aes_d1_i,aes_d2_i,aes_d3_i} registered; core_start=1 for exactly this cycle; timeout counter=0; go WAIT.
- WAIT: counter increments each cycle.
  - core_done=1 -> latch aes_res0_o=core_res[127:96], res1=[95:64], res2=[63:32], res3=[31:0]; go DONE.
  - Else if counter reaches TIMEOUT-1 -> aes_res*=0, err=1, go DONE.
  - core_done in the same cycle as expiry: done wins, err stays 0.
- DONE (1 cycle): aes_done=1; go IDLE. aes_res* hold their value until the next completion.
- core_done outside WAIT is ignored. mem_ack outside FETCH is ignored.
- exception_pending only gates the trigger; it does not abort an operation in flight.
- Minimum latency with zero-wait acks, trigger edge to aes_done high: 4 (FETCH) + 1 (START) + N (core) + 1 (DONE) cycles.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values; an outstanding memory read is abandoned.

Test Plan:
- Reset then idle: nrst low mid-cycle -> all outputs 0 asynchronously; no mem_req without a trigger.
- Basic op: write csr_wb=0x0000_1003 to 0x7C4 with zero-wait acks returning 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - mem_addr sequence is 0x1000, 0x1004, 0x1008, 0x100C.
  - core_key=0x11111111_22222222_33333333_44444444; core_start pulses once.
  - Core returns 0xA..B..C..D words after 10 cycles -> aes_done pulses once, aes_res0..3 match, err=0.
- Wait-state memory: ack delayed 3 cycles per word -> mem_addr held stable while mem_req=1; same key result; total latency grows by 12 cycles.
- Suppression: trigger write with exception_pending=1 -> busy stays 0. Second trigger while busy -> ignored; exactly one aes_done.
- Timeout: TIMEOUT=8, core never responds -> aes_done 8 cycles after core_start window, err=1, aes_res*=0. Next trigger clears err.
- Boundaries:
  - core_done exactly at expiry -> err=0, results latched.
  - base 0xFFFF_FFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
  - nrst asserted in WAIT -> IDLE, no aes_done.

Source files
------------

// File: rtl/aes_seq_ctrl.sv
// Sequencer for one AES-128 operation: key fetch over a req/ack read port,
// core start/wait with timeout, and a one-cycle completion pulse with results.
module aes_seq_ctrl #(
    parameter logic [11:0] TRIG_ADDR = 12'h7C4,
    parameter int          TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         csr_we,
    input  logic [11:0]  csr_address_wb,
    input  logic [31:0]  csr_wb,
    input  logic         exception_pending,
    input  logic [31:0]  aes_d0_i,
    input  logic [31:0]  aes_d1_i,
    input  logic [31:0]  aes_d2_i,
    input  logic [31:0]  aes_d3_i,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_data,
    input  logic         core_done,
    input  logic [127:0] core_res,
    output logic         aes_done,
    output logic [31:0]  aes_res0_o,
    output logic [31:0]  aes_res1_o,
    output logic [31:0]  aes_res2_o,
    output logic [31:0]  aes_res3_o,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, DONE} state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_t             state;
    logic [1:0]         cnt;
    logic [15:0]        tcnt;
    logic [3:0][31:0]   key_words;
    logic               trig;

    assign trig     = csr_we && (csr_address_wb == TRIG_ADDR) && !exception_pending;
    assign busy     = (state != IDLE);
    assign core_key = key_words;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            tcnt       <= 16'd0;
            key_words  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            core_start <= 1'b0;
            core_data  <= '0;
            aes_done   <= 1'b0;
            aes_res0_o <= 32'd0;
            aes_res1_o <= 32'd0;
            aes_res2_o <= 32'd0;
            aes_res3_o <= 32'd0;
            err        <= 1'b0;
        end else begin
            core_start <= 1'b0;
            aes_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        mem_addr <= {csr_wb[31:2], 2'b00};
                        mem_req  <= 1'b1;
                        cnt      <= 2'd0;
                        err      <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        // first word lands in the top lane: lane index is 3-cnt == ~cnt
                        key_words[~cnt] <= mem_rdata;
                        cnt             <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            mem_req    <= 1'b0;
                            core_start <= 1'b1;
                            core_data  <= {aes_d0_i, aes_d1_i, aes_d2_i, aes_d3_i};
                            tcnt       <= 16'd0;
                            state      <= START;
                        end else begin
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // completion takes priority over an expiry in the same cycle
                    if (core_done) begin
                        aes_res0_o <= core_res[127:96];
                        aes_res1_o <= core_res[95:64];
                        aes_res2_o <= core_res[63:32];
                        aes_res3_o <= core_res[31:0];
                        aes_done   <= 1'b1;
                        state      <= DONE;
                    end else if (tcnt == TLAST) begin
                        aes_res0_o <= 32'd0;
                        aes_res1_o <= 32'd0;
                        aes_res2_o <= 32'd0;
                        aes_res3_o <= 32'd0;
                        err        <= 1'b1;
                        aes_done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: vector table with memory/core models and a result
// scoreboard, plus directed sequences for suppression, retrigger and reset.
module tb_aes_seq_ctrl;
    localparam int TO = 12;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         csr_we = 1'b0;
    logic [11:0]  csr_address_wb = 12'd0;
    logic [31:0]  csr_wb = 32'd0;
    logic         exception_pending = 1'b0;
    logic [31:0]  aes_d0_i = 32'd0, aes_d1_i = 32'd0, aes_d2_i = 32'd0, aes_d3_i = 32'd0;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = 32'd0;
    logic         core_start;
    logic [127:0] core_key, core_data;
    logic         core_done = 1'b0;
    logic [127:0] core_res = '0;
    logic         aes_done;
    logic [31:0]  aes_res0_o, aes_res1_o, aes_res2_o, aes_res3_o;
    logic         busy, err;

    aes_seq_ctrl #(.TRIG_ADDR(12'h7C4), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst), .csr_we(csr_we), .csr_address_wb(csr_address_wb),
        .csr_wb(csr_wb), .exception_pending(exception_pending),
        .aes_d0_i(aes_d0_i), .aes_d1_i(aes_d1_i), .aes_d2_i(aes_d2_i), .aes_d3_i(aes_d3_i),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .core_start(core_start), .core_key(core_key), .core_data(core_data),
        .core_done(core_done), .core_res(core_res), .aes_done(aes_done),
        .aes_res0_o(aes_res0_o), .aes_res1_o(aes_res1_o), .aes_res2_o(aes_res2_o),
        .aes_res3_o(aes_res3_o), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  csr;
        logic [31:0]  base;
        logic [127:0] key;
        logic [127:0] pt;
        int           ack_dly;
        int           core_lat;   // 0: core never answers
        logic [127:0] core_res;
        logic [127:0] exp_res;
        logic         exp_err;
        int           exp_lat;    // trigger edge to aes_done seen high, in cycles
    } vec_t;

    typedef struct {
        logic [127:0] res;
        logic         err;
        int           lat;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, dones = 0, starts = 0, t0 = 0;

    logic [3:0][31:0] cur_key;
    logic [31:0]      cur_base;
    logic [127:0]     cur_pt, cur_res;
    int               cur_ack_dly, cur_lat;
    int               word_idx, wait_cnt, core_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({mem_req, mem_addr, core_start, aes_done, busy, err}) |
               core_key | core_data |
               {aes_res0_o, aes_res1_o, aes_res2_o, aes_res3_o};
    endfunction

    // memory: acks after ack_dly waiting cycles, address checked every request cycle
    initial begin : mem_model
        logic [31:0] exp_a;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (nrst && mem_req) begin
                exp_a = cur_base + 32'(4 * word_idx);
                chk("mem_addr", 128'(mem_addr), 128'(exp_a));
                if (word_idx > 3) begin
                    chk("extra_req", 128'(mem_req), 128'(0));
                end else if (wait_cnt < cur_ack_dly) begin
                    wait_cnt++;
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur_key[3 - word_idx];
                    word_idx++;
                    wait_cnt  = 0;
                end
            end
        end
    end

    // core: answers core_lat cycles into WAIT with cur_res
    initial begin : core_model
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!nrst) begin
                core_cnt = 0;
            end else begin
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        core_done = 1'b1;
                        core_res  = cur_res;
                    end
                end
                if (core_start) begin
                    starts++;
                    chk("core_key", core_key, cur_key);
                    chk("core_data", core_data, cur_pt);
                    core_cnt = cur_lat;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (aes_done) begin
                dones++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 128'(aes_done), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("aes_res", {aes_res0_o, aes_res1_o, aes_res2_o, aes_res3_o}, e.res);
                    chk("err", 128'(err), 128'(e.err));
                    chk("latency", 128'(cyc - t0), 128'(e.lat));
                end
            end
        end
    end

    task automatic write_csr(input logic [11:0] a, input logic [31:0] d, input logic exc,
                             output int edge_cyc);
        @(posedge clk);
        #1;
        csr_we = 1'b1; csr_address_wb = a; csr_wb = d; exception_pending = exc;
        @(posedge clk);
        edge_cyc = cyc;
        #1;
        csr_we = 1'b0; exception_pending = 1'b0;
    endtask

    task automatic start_op(input int i, input bit push);
        exp_t e;
        int   tc;
        cur_key = vecs[i].key;   cur_base = vecs[i].base;  cur_pt = vecs[i].pt;
        cur_res = vecs[i].core_res; cur_ack_dly = vecs[i].ack_dly; cur_lat = vecs[i].core_lat;
        word_idx = 0; wait_cnt = 0;
        {aes_d0_i, aes_d1_i, aes_d2_i, aes_d3_i} = vecs[i].pt;
        if (push) begin
            e.res = vecs[i].exp_res; e.err = vecs[i].exp_err; e.lat = vecs[i].exp_lat;
            sb.push_back(e);
        end
        write_csr(12'h7C4, vecs[i].csr, 1'b0, tc);
        t0 = tc;
        chk("busy_after_trig", 128'(busy), 128'(1));
        chk("err_cleared", 128'(err), 128'(0));
    endtask

    task automatic wait_done(input int n0, input int bound);
        int k = 0;
        while (dones == n0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (dones == n0) chk("done_timeout", 128'(0), 128'(1));
    endtask

    initial begin : driver
        int n0, s0, tc;
        vecs[0] = '{csr:32'h0000_1003, base:32'h0000_1000,
                    key:128'h11111111_22222222_33333333_44444444,
                    pt:128'h01020304_05060708_090A0B0C_0D0E0F10, ack_dly:0, core_lat:10,
                    core_res:128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
                    exp_res:128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, exp_err:1'b0, exp_lat:16};
        vecs[1] = '{csr:32'h0000_1003, base:32'h0000_1000,
                    key:128'h11111111_22222222_33333333_44444444,
                    pt:128'h01020304_05060708_090A0B0C_0D0E0F10, ack_dly:3, core_lat:10,
                    core_res:128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
                    exp_res:128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, exp_err:1'b0, exp_lat:28};
        vecs[2] = '{csr:32'h0000_3000, base:32'h0000_3000,
                    key:128'hDEADBEEF_00000001_00000002_00000003,
                    pt:128'h0, ack_dly:0, core_lat:0, core_res:128'hFFFF,
                    exp_res:128'h0, exp_err:1'b1, exp_lat:6 + TO};
        vecs[3] = '{csr:32'h0000_2000, base:32'h0000_2000,
                    key:128'h01234567_89ABCDEF_FEDCBA98_76543210,
                    pt:128'hFFFFFFFF_00000000_12345678_9ABCDEF0, ack_dly:0, core_lat:1,
                    core_res:128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0,
                    exp_res:128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0, exp_err:1'b0, exp_lat:7};
        vecs[4] = '{csr:32'h0000_4002, base:32'h0000_4000,
                    key:128'hCAFEBABE_12121212_34343434_56565656,
                    pt:128'h1, ack_dly:0, core_lat:TO,
                    core_res:128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF,
                    exp_res:128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF, exp_err:1'b0, exp_lat:6 + TO};
        vecs[5] = '{csr:32'hFFFF_FFFB, base:32'hFFFF_FFF8,
                    key:128'h0BADF00D_1BADF00D_2BADF00D_3BADF00D,
                    pt:128'h2, ack_dly:1, core_lat:5,
                    core_res:128'h77777777_88888888_99999999_66666666,
                    exp_res:128'h77777777_88888888_99999999_66666666, exp_err:1'b0, exp_lat:15};
        cur_key = '0; cur_base = '0; cur_pt = '0; cur_res = '0;
        cur_ack_dly = 0; cur_lat = 0; word_idx = 0; wait_cnt = 0; core_cnt = 0;

        #12;
        chk("reset_outputs", all_outs(), 128'(0));
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("idle_no_req", 128'({mem_req, busy}), 128'(0));
        end

        for (int i = 0; i < 6; i++) begin
            n0 = dones; s0 = starts;
            start_op(i, 1'b1);
            wait_done(n0, 80);
            @(negedge clk);
            chk("start_pulses", 128'(starts - s0), 128'(1));
            chk("done_pulses", 128'(dones - n0), 128'(1));
            chk("idle_after", 128'(busy), 128'(0));
        end

        // suppressed trigger and non-trigger address leave the block idle
        n0 = dones;
        write_csr(12'h7C4, 32'h0000_8000, 1'b1, tc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("suppressed_busy", 128'(busy), 128'(0));
        end
        write_csr(12'h7C5, 32'h0000_8000, 1'b0, tc);
        @(negedge clk);
        chk("other_addr_busy", 128'({busy, mem_req}), 128'(0));

        // retriggers while busy are dropped
        n0 = dones; s0 = starts;
        start_op(0, 1'b1);
        write_csr(12'h7C4, 32'h0000_5000, 1'b0, tc);
        repeat (4) @(posedge clk);
        write_csr(12'h7C4, 32'h0000_6000, 1'b0, tc);
        wait_done(n0, 80);
        repeat (25) @(negedge clk);
        chk("retrig_dones", 128'(dones - n0), 128'(1));
        chk("retrig_starts", 128'(starts - s0), 128'(1));
        chk("retrig_idle", 128'(busy), 128'(0));

        // reset asserted in WAIT: immediate return to idle, no completion
        n0 = dones;
        start_op(2, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        chk("wait_reset_outputs", all_outs(), 128'(0));
        @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("wait_reset_no_done", 128'(dones - n0), 128'(0));
        chk("wait_reset_idle", 128'({busy, mem_req}), 128'(0));

        n0 = dones;
        start_op(3, 1'b1);
        wait_done(n0, 80);
        @(negedge clk);
        chk("recover_sb_empty", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
